mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers; sits in the EX stage beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX.
- Runs multi-cycle multiply and divide operations.
- Drives the busy flag that the pipeline stall logic combines with the ID-stage HI/LO-access flag to hold IF/ID.
- HI/LO feed the EX-stage MFHI/MFLO result mux.

Parameters:
- MUL_LAT, 4, busy cycles for a multiply (range 1..31).
- DIV_ITER, 32, divide iteration cycles; fixed at data width, not overridable in practice.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- md_op  in  3  EX op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src_b  in  32  rt operand (divisor / multiplier)
- ex_hold  in  1  EX stage frozen this cycle (icache/dcache/hazard stall)
- ex_flush  in  1  EX instruction cancelled this cycle (MEM exception or eret flush)
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse in the cycle after HI/LO are updated by MUL/DIV
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset, when rst==0 at a clk edge: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts the operation; no HI/LO write occurs.
- accept = (md_op in 1..6) && !ex_hold && !ex_flush && state==IDLE.
  - Ops arriving while not IDLE are ignored. The stall unit guarantees this does not happen.
  - ex_hold prevents a frozen EX instruction from re-issuing.
- MTHI/MTLO: on an accept edge, hi (or lo) = src_a. Visible the next cycle. State stays IDLE; busy stays 0.
- States: IDLE, MUL, DIV, FIX.
- MUL/MULTU:
  - On the accept edge, latch operands and sign mode; go to MUL; counter=MUL_LAT-1.
  - The 64-bit product is formed with a signed or unsigned 32x32 multiply, registered internally.
  - In MUL, decrement each edge. At the edge where counter==0: {hi,lo}=product, state=IDLE.
  - busy=1 for exactly MUL_LAT cycles after the accept edge.
- DIV/DIVU:
  - On the accept edge, latch |a| and |b| (signed ops) or the raw values (unsigned); record the sign of a and the sign of a^b.
  - Go to DIV; counter=DIV_ITER-1.
  - Restoring division, 1 quotient bit per edge, MSB first; the partial remainder is 33 bits.
  - After the last iteration edge, go to FIX.
  - FIX edge: quotient is negated if the sign bit was set (signed only); remainder takes the sign of the dividend. Then lo=quotient, hi=remainder, state=IDLE.
  - busy=1 for DIV_ITER+1 = 33 cycles.
- Divide by zero (src_b==0, any sign mode): lo=32'hFFFFFFFF, hi=src_a. Same 33-cycle latency; the result is overridden in FIX.
- 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0. No trap.
- busy = (state!=IDLE), registered-state derived. It is 0 in the cycle HI/LO first show the new result.
- done=1 for the one cycle after the completing edge. done is never asserted for MTHI/MTLO.
- In-flight operations are never cancelled by ex_flush: the owning instruction has already left EX. ex_flush only blocks acceptance in the same cycle.
- hi/lo change only on MTHI/MTLO accept, MUL completion, FIX, or reset.

Decomposition:
- Shared package (mdu_pkg):
  - md_op encodings MD_NONE..MD_MTLO
  - state encodings IDLE/MUL/DIV/FIX
  - DATA_W=32
- One sub-module, div_iter: iterative unsigned restoring divider core (start, dividend, divisor → quotient, remainder, valid).
- Sign handling, the multiplier, the FSM and HI/LO stay in mdu_hilo.

Test Plan:
- MULT, src_a=0xFFFFFFFE (-2), src_b=3, no hold → busy high 4 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- MULTU, src_a=0xFFFFFFFF, src_b=0xFFFFFFFF → after 4 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV, src_a=-7 (0xFFFFFFF9), src_b=2 → busy 33 cycles. Then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU 100/7 → lo=14, hi=2.
- DIVU, src_b=0, src_a=0x1234 → after 33 cycles lo=0xFFFFFFFF, hi=0x1234. Also DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- MULT presented with ex_hold=1 for 3 cycles, then released → exactly one accept, on the release cycle; busy counts from there. MTLO with ex_flush=1 → lo unchanged.
- DIV in flight, rst=0 at cycle 10 → busy=0, hi=lo=0 next cycle. MTHI 0xA5A5A5A5 issued while busy → ignored. MTHI issued when idle → hi=0xA5A5A5A5 next cycle, busy stays 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and widths for the multiply/divide unit
package mdu_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;
endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: EX-stage request and HI/LO result bundle of the multiply/divide unit
interface mdu_hilo_if;
  import mdu_pkg::*;
  logic [2:0] md_op;
  logic [DATA_W-1:0] src_a, src_b, hi, lo;
  logic ex_hold, ex_flush, busy, done;
  modport master(output md_op, src_a, src_b, ex_hold, ex_flush, input busy, done, hi, lo);
  modport slave(input md_op, src_a, src_b, ex_hold, ex_flush, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_hilo_div_iter.sv
// div_iter: unsigned restoring divider, one quotient bit per clock, MSB first
module div_iter import mdu_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              valid
);
  logic [DATA_W-1:0] q, r, d;
  logic [$clog2(DATA_W)-1:0] cnt;
  logic run, ge;
  logic [DATA_W:0] sh;
  assign sh = {r, q[DATA_W-1]};
  assign ge = sh >= {1'b0, d};
  assign valid = run && cnt == '0;
  assign quotient = q;
  assign remainder = r;
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
      r <= '0;
      d <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      q <= dividend;
      r <= '0;
      d <= divisor;
      cnt <= '1;
      run <= 1'b1;
    end else if (run) begin
      r <= ge ? sh[DATA_W-1:0] - d : sh[DATA_W-1:0];
      q <= {q[DATA_W-2:0], ge};
      cnt <= cnt - 1'b1;
      run <= cnt != '0;
    end
  end
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit owning the architectural HI/LO registers
module mdu_hilo import mdu_pkg::*; #(
  parameter int MUL_LAT  = 4,
  parameter int DIV_ITER = DATA_W
) (
  input logic       clk,
  input logic       rst,
  mdu_hilo_if.slave m
);
  state_e state, state_n;
  logic [4:0] cnt;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0] hi, lo, a_raw, dv_a, dv_b, dv_q, dv_r;
  logic neg_q, neg_r, dz, done, dv_valid;
  logic accept, mul_s, div_s, is_mul, is_div;
  assign accept = m.md_op inside {[3'd1:3'd6]} && !m.ex_hold && !m.ex_flush && state == IDLE;
  assign mul_s = m.md_op == MD_MULT;
  assign div_s = m.md_op == MD_DIV;
  assign is_mul = mul_s || m.md_op == MD_MULTU;
  assign is_div = div_s || m.md_op == MD_DIVU;
  assign dv_a = (div_s && m.src_a[DATA_W-1]) ? -m.src_a : m.src_a;
  assign dv_b = (div_s && m.src_b[DATA_W-1]) ? -m.src_b : m.src_b;
  assign m.busy = state != IDLE;
  assign m.done = done;
  assign m.hi = hi;
  assign m.lo = lo;
  div_iter u_div (
    .clk(clk),
    .rst(rst),
    .start(accept && is_div),
    .dividend(dv_a),
    .divisor(dv_b),
    .quotient(dv_q),
    .remainder(dv_r),
    .valid(dv_valid)
  );
  always_ff @(posedge clk) state <= !rst ? IDLE : state_n;
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (!accept ? IDLE : is_mul ? MUL : is_div ? DIV : IDLE)
            : state == MUL  ? (cnt == '0 ? IDLE : MUL)
            : state == DIV  ? (dv_valid ? FIX : DIV)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      done <= 1'b0;
      prod <= '0;
      a_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else begin
      done <= (state == MUL && cnt == '0) || state == FIX;
      if (accept && m.md_op == MD_MTHI) hi <= m.src_a;
      if (accept && m.md_op == MD_MTLO) lo <= m.src_a;
      if (accept && is_mul) begin
        prod <= $signed({{DATA_W{mul_s & m.src_a[DATA_W-1]}}, m.src_a})
              * $signed({{DATA_W{mul_s & m.src_b[DATA_W-1]}}, m.src_b});
        cnt <= 5'(MUL_LAT - 1);
      end
      if (accept && is_div) begin
        a_raw <= m.src_a;
        neg_q <= div_s & (m.src_a[DATA_W-1] ^ m.src_b[DATA_W-1]);
        neg_r <= div_s & m.src_a[DATA_W-1];
        dz <= m.src_b == '0;
        cnt <= 5'(DIV_ITER - 1);
      end
      if ((state == MUL || state == DIV) && cnt != '0) cnt <= cnt - 1'b1;
      if (state == MUL && cnt == '0) {hi, lo} <= prod;
      // divide-by-zero reports all-ones quotient and the untouched dividend
      if (state == FIX) begin
        lo <= dz ? '1 : neg_q ? -dv_q : dv_q;
        hi <= dz ? a_raw : neg_r ? -dv_r : dv_r;
      end
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed vectors with a done-driven scoreboard for HI/LO results
module tb_mdu_hilo;
  import mdu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0, bad = 0, ndone = 0, nexp = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_v;
  always #5 clk = ~clk;
  mdu_hilo_if bus();
  mdu_hilo dut (.clk(clk), .rst(rst), .m(bus));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    cyc();
    bus.md_op = MD_NONE;
  endtask
  task automatic wait_busy(input string name, input int exp_busy);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      cyc();
      n++;
    end
    chk(name, 64'(n), 64'(exp_busy));
  endtask
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_busy);
    sb.push_back(exp);
    nexp++;
    drive(op, a, b);
    wait_busy(name, exp_busy);
  endtask
  always @(negedge clk) begin
    if (rst && bus.done) begin
      ndone++;
      if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        exp_v = sb.pop_front();
        chk("result", {bus.hi, bus.lo}, exp_v);
        chk("busy_at_done", 64'(bus.busy), 64'd0);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    bus.md_op = MD_NONE;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.ex_hold = 1'b0;
    bus.ex_flush = 1'b0;
    repeat (3) cyc();
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    rst = 1'b1;
    cyc();
    run_op("mult_busy", MD_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 4);
    run_op("multu_busy", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 4);
    run_op("div_busy", MD_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    run_op("divu_busy", MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_op("div_neg_b", MD_DIV, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
    run_op("divu_zero", MD_DIVU, 32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF}, 33);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33);
    bus.ex_hold = 1'b1;
    bus.md_op = MD_MULT;
    bus.src_a = 32'd5;
    bus.src_b = 32'd6;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_busy", 64'(bus.busy), 64'd0);
    end
    sb.push_back({32'd0, 32'd30});
    nexp++;
    bus.ex_hold = 1'b0;
    cyc();
    bus.md_op = MD_NONE;
    wait_busy("hold_release_busy", 4);
    cyc();
    bus.ex_flush = 1'b1;
    drive(MD_MTLO, 32'hDEADBEEF, 32'd0);
    bus.ex_flush = 1'b0;
    chk("flush_mtlo_lo", 64'(bus.lo), 64'd30);
    drive(MD_MTLO, 32'h55, 32'd0);
    chk("mtlo_lo", 64'(bus.lo), 64'h55);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    cyc();
    chk("mtlo_done", 64'(bus.done), 64'd0);
    drive(MD_MTHI, 32'h11, 32'd0);
    chk("mthi_pre", 64'(bus.hi), 64'h11);
    drive(MD_DIV, 32'd1000, 32'd3);
    chk("inflight_busy", 64'(bus.busy), 64'd1);
    repeat (8) cyc();
    rst = 1'b0;
    cyc();
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b1;
    repeat (2) cyc();
    chk("midrst_after_busy", 64'(bus.busy), 64'd0);
    sb.push_back({32'd0, 32'd6});
    nexp++;
    drive(MD_MULT, 32'd2, 32'd3);
    drive(MD_MTHI, 32'hA5A5A5A5, 32'd0);
    chk("mthi_busy_ignored", 64'(bus.hi), 64'd0);
    wait_busy("mult_after_mthi_busy", 3);
    cyc();
    drive(MD_MTHI, 32'hA5A5A5A5, 32'd0);
    chk("mthi_idle_hi", 64'(bus.hi), 64'hA5A5A5A5);
    chk("mthi_idle_busy", 64'(bus.busy), 64'd0);
    repeat (3) cyc();
    chk("done_count", 64'(ndone), 64'(nexp));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
